// File: rtl/edid_pkg.sv
// Shared types and constants for the EDID block checker: FSM states, the
// fixed 8-byte EDID header and the offsets of the fields we extract.
package edid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_BODY   = 2'd2,
        ST_DONE   = 2'd3
    } edid_state_e;

    localparam logic [63:0] EDID_HEADER = 64'h00FF_FFFF_FFFF_FF00;

    localparam logic [6:0] OFS_MFG_HI = 7'd8;
    localparam logic [6:0] OFS_MFG_LO = 7'd9;
    localparam logic [6:0] OFS_VER    = 7'd18;
    localparam logic [6:0] OFS_REV    = 7'd19;
    localparam logic [6:0] OFS_PIX_LO = 7'd54;
    localparam logic [6:0] OFS_PIX_HI = 7'd55;

    // Byte 0 is the most significant byte of EDID_HEADER.
    function automatic logic [7:0] header_byte(input logic [2:0] idx);
        return EDID_HEADER[8 * (7 - int'(idx)) +: 8];
    endfunction

endpackage

// File: rtl/edid_byte_timer.sv
// Byte-gap watchdog: counts cycles since the last reload while run is high
// and flags expired once TIMEOUT_CYC cycles have elapsed.
module edid_byte_timer #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk_4MHz,
    input  logic rst,
    input  logic reload,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC));

    // Saturate at the limit so expired stays asserted until the next reload.
    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = '0;
        end else if (run && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_4MHz) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/edid_block_checker.sv
// Captures one EDID block byte by byte, validates header and checksum, and
// extracts manufacturer ID, version/revision and the first pixel clock.
module edid_block_checker
    import edid_pkg::*;
#(
    parameter int BLOCK_LEN   = 128,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk_4MHz,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        header_ok,
    output logic        checksum_ok,
    output logic        error,
    output logic [15:0] mfg_id,
    output logic [7:0]  edid_ver,
    output logic [7:0]  edid_rev,
    output logic [15:0] pixclk_10khz
);

    localparam logic [6:0] LAST_IDX = 7'(BLOCK_LEN - 1);

    edid_state_e state_q, state_d;
    logic [6:0]  idx_q, idx_d;
    logic [7:0]  sum_q, sum_d;
    logic        hdr_flag_q, hdr_flag_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        header_ok_q, header_ok_d;
    logic        checksum_ok_q, checksum_ok_d;
    logic        error_q, error_d;
    logic [15:0] mfg_id_q, mfg_id_d;
    logic [7:0]  edid_ver_q, edid_ver_d;
    logic [7:0]  edid_rev_q, edid_rev_d;
    logic [15:0] pixclk_q, pixclk_d;

    logic accept;
    logic timer_run;
    logic timer_expired;

    assign timer_run = (state_q == ST_HEADER) || (state_q == ST_BODY);

    edid_byte_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_byte_timer (
        .clk_4MHz (clk_4MHz),
        .rst      (rst),
        .reload   (start | accept),
        .run      (timer_run),
        .expired  (timer_expired)
    );

    // start outranks everything; abort/timeout outrank a same-cycle byte.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        sum_d         = sum_q;
        hdr_flag_d    = hdr_flag_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        header_ok_d   = header_ok_q;
        checksum_ok_d = checksum_ok_q;
        error_d       = error_q;
        mfg_id_d      = mfg_id_q;
        edid_ver_d    = edid_ver_q;
        edid_rev_d    = edid_rev_q;
        pixclk_d      = pixclk_q;
        accept        = 1'b0;

        if (start) begin
            state_d       = ST_HEADER;
            idx_d         = '0;
            sum_d         = '0;
            hdr_flag_d    = 1'b1;
            busy_d        = 1'b1;
            header_ok_d   = 1'b0;
            checksum_ok_d = 1'b0;
            error_d       = 1'b0;
            mfg_id_d      = '0;
            edid_ver_d    = '0;
            edid_rev_d    = '0;
            pixclk_d      = '0;
        end else begin
            case (state_q)
                ST_HEADER, ST_BODY: begin
                    if (abort || timer_expired) begin
                        state_d       = ST_DONE;
                        busy_d        = 1'b0;
                        done_d        = 1'b1;
                        error_d       = 1'b1;
                        header_ok_d   = 1'b0;
                        checksum_ok_d = 1'b0;
                    end else if (byte_valid) begin
                        accept = 1'b1;
                        idx_d  = idx_q + 7'd1;
                        sum_d  = sum_q + byte_data;
                        if (idx_q < 7'd8 && byte_data != header_byte(idx_q[2:0])) begin
                            hdr_flag_d = 1'b0;
                        end
                        case (idx_q)
                            OFS_MFG_HI: mfg_id_d[15:8] = byte_data;
                            OFS_MFG_LO: mfg_id_d[7:0]  = byte_data;
                            OFS_VER:    edid_ver_d     = byte_data;
                            OFS_REV:    edid_rev_d     = byte_data;
                            OFS_PIX_LO: pixclk_d[7:0]  = byte_data;
                            OFS_PIX_HI: pixclk_d[15:8] = byte_data;
                            default: ;
                        endcase
                        if (state_q == ST_HEADER && idx_q == 7'd7) begin
                            state_d = ST_BODY;
                        end
                        if (state_q == ST_BODY && idx_q == LAST_IDX) begin
                            state_d       = ST_DONE;
                            busy_d        = 1'b0;
                            done_d        = 1'b1;
                            header_ok_d   = hdr_flag_d;
                            checksum_ok_d = (sum_d == 8'd0);
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_4MHz) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            sum_q         <= '0;
            hdr_flag_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            header_ok_q   <= 1'b0;
            checksum_ok_q <= 1'b0;
            error_q       <= 1'b0;
            mfg_id_q      <= '0;
            edid_ver_q    <= '0;
            edid_rev_q    <= '0;
            pixclk_q      <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            sum_q         <= sum_d;
            hdr_flag_q    <= hdr_flag_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            header_ok_q   <= header_ok_d;
            checksum_ok_q <= checksum_ok_d;
            error_q       <= error_d;
            mfg_id_q      <= mfg_id_d;
            edid_ver_q    <= edid_ver_d;
            edid_rev_q    <= edid_rev_d;
            pixclk_q      <= pixclk_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign header_ok    = header_ok_q;
    assign checksum_ok  = checksum_ok_q;
    assign error        = error_q;
    assign mfg_id       = mfg_id_q;
    assign edid_ver     = edid_ver_q;
    assign edid_rev     = edid_rev_q;
    assign pixclk_10khz = pixclk_q;

endmodule
